rf_frontend_ctrl: RTL and testbench
===================================

Name: rf_frontend_ctrl

Overview:
Applies front-end switch, filter and VCO load-enable settings on the WSA1000 (VSWA..D, FILTER_A0/1, VCO_LE) from writes on the serial settings bus.
Sequences each change as break-before-make with settling delays, then pulses VCO load-enable and checks VCO_MUXOUT for lock with a timeout.
Sits beside rx_chain and adc_interface on the serial_addr/serial_data/serial_strobe bus, in the adcclk domain. The status word feeds a serial_io readback slot.

Parameters:
ADDR, 7'd48, serial register address decoded by this block.
BREAK_CYCLES, 16'd50, cycles all switches are held open before new settings are applied.
SETTLE_CYCLES, 16'd500, cycles after make before the VCO step begins.
LE_CYCLES, 8'd4, width of the VCO_LE high pulse.
LOCK_STABLE, 8'd16, consecutive synced-high muxout cycles that qualify as lock.
LOCK_TIMEOUT, 24'd50000, maximum cycles spent in LOCK_WAIT.

Ports:
clock  in  1  block clock (adcclk, 50 MHz)
reset  in  1  asynchronous, active-high reset
serial_addr  in  7  settings bus address
serial_data  in  32  settings bus data
serial_strobe  in  1  settings bus write strobe, one cycle
vco_muxout  in  1  VCO MUXOUT lock-detect pin (asynchronous)
vsw  out  4  {VSWD,VSWC,VSWB,VSWA}
filter_a  out  2  {FILTER_A1,FILTER_A0}
vco_le  out  1  VCO load enable
busy  out  1  sequence in progress
locked  out  1  last lock check passed
lock_timeout  out  1  last lock check timed out
status  out  32  readback word

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; pending flag cleared; counters 0.
- Write decode: serial_strobe && serial_addr==ADDR. Register fields:
  - [3:0] vsw
  - [5:4] filter
  - [8] do_vco (run the LE pulse and lock check)
  - [31:9], [7:6] ignored
- Write arriving in IDLE: captured; state goes to BREAK on the next edge; busy=1 from that edge.
- Write arriving while busy: stored in a one-deep pending register; a later write overwrites it. On return to IDLE with pending set, BREAK is entered on the next cycle and pending is cleared.
- State machine (all outputs registered):
  - IDLE: busy=0.
  - BREAK: vsw=0, filter_a holds its old value; lasts BREAK_CYCLES cycles, then MAKE.
  - MAKE: vsw and filter_a take the new values on entry; lasts SETTLE_CYCLES cycles. Then LE_PULSE if do_vco, else IDLE.
  - LE_PULSE: vco_le=1 for exactly LE_CYCLES cycles; locked and lock_timeout cleared on entry; then LOCK_WAIT.
  - LOCK_WAIT: vco_muxout passes through a 2-flop synchronizer. A stable counter increments while the synced value is 1 and resets to 0 when it is 0.
    - Stable count reaches LOCK_STABLE: locked=1, go to IDLE.
    - LOCK_TIMEOUT cycles elapse first: lock_timeout=1, go to IDLE.
    - If both happen in the same cycle, lock wins.
- A count parameter of 0 is treated as 1: each state lasts at least one cycle.
- Counters are wide enough for their parameter; no wrap occurs inside a state. The lock_checks counter (8-bit) wraps 255->0.
- locked and lock_timeout hold until the next LE_PULSE entry.
- status word:
  - [3:0] current vsw
  - [5:4] current filter_a
  - [8] busy
  - [9] locked
  - [10] lock_timeout
  - [11] pending
  - [14:12] state code: IDLE=0, BREAK=1, MAKE=2, LE_PULSE=3, LOCK_WAIT=4
  - [23:16] lock_checks counter, incremented on each LE_PULSE entry
  - remaining bits 0
- Reset asserted mid-sequence: outputs go to 0 immediately (switches open, vco_le low); the pending write is lost.

Decomposition:
- Shared package holds the state encoding constants (used in both the RTL and the status field) and the default ADDR, to be added to the register map as FR_FRONTEND.
- One sub-module: sync_debounce, a 2-flop synchronizer plus stable counter with LOCK_STABLE parameter and a clear input. It is reused later for other asynchronous status pins.

Test Plan:
1. Reset, then write 0x0000_002A to ADDR with do_vco=0.
   - busy rises the next cycle; vsw=0 for 50 cycles; then vsw=4'hA, filter_a=2'b10; busy falls 500 cycles later; vco_le never asserts.
2. Write 0x0000_0105 with vco_muxout held high.
   - vco_le high for exactly 4 cycles; locked=1 at 2 (sync) + 16 cycles after LOCK_WAIT entry; status[23:16]=1.
3. Write 0x0000_0103 with vco_muxout held low.
   - lock_timeout=1 exactly 50000 cycles after LOCK_WAIT entry; locked=0; busy=0; status[10]=1.
4. vco_muxout toggling every 10 cycles during LOCK_WAIT.
   - No lock (stable counter never reaches 16); result is timeout.
5. Write A (vsw=1) then two more writes B (vsw=2) and C (vsw=4) during A's MAKE.
   - After A completes, one BREAK/MAKE sequence runs with vsw=4; B is never applied; status[11]=1 during A's remaining cycles.
6. Assert reset during LE_PULSE.
   - vco_le, vsw, filter_a and busy are 0 the same instant (asynchronous); after release state is IDLE and status=0.
   - Also: a write to ADDR+1 produces no change.

Source files
------------

// File: rtl/rf_frontend_ctrl_pkg.sv
// Shared definitions for the RF front-end sequencer: state codes (also reported in
// the status word), the settings command layout and the default register address.
package rf_frontend_ctrl_pkg;

  localparam logic [6:0] FR_FRONTEND = 7'd48;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BREAK     = 3'd1,
    ST_MAKE      = 3'd2,
    ST_LE_PULSE  = 3'd3,
    ST_LOCK_WAIT = 3'd4
  } fe_state_e;

  typedef struct packed {
    logic       do_vco;
    logic [1:0] filter;
    logic [3:0] vsw;
  } fe_cmd_t;

  function automatic fe_cmd_t decode_cmd(input logic [8:0] field);
    fe_cmd_t cmd;
    cmd.vsw    = field[3:0];
    cmd.filter = field[5:4];
    cmd.do_vco = field[8];
    return cmd;
  endfunction

  // Terminal count for a state lasting 'cycles' cycles; zero still lasts one cycle.
  function automatic logic [23:0] last_count(input logic [23:0] cycles);
    return (cycles == 24'd0) ? 24'd0 : cycles - 24'd1;
  endfunction

endpackage

// File: rtl/rf_frontend_ctrl_sync_debounce.sv
// Two-flop synchronizer plus consecutive-high counter for an asynchronous status pin.
// stable_hit is high in the cycle where the synced input completes STABLE highs in a row.
module sync_debounce #(
  parameter logic [7:0] STABLE = 8'd16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic async_in,
  output logic synced,
  output logic stable_hit
);

  localparam logic [7:0] TARGET = (STABLE == 8'd0) ? 8'd1 : STABLE;

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic [7:0] count_q, count_d;

  // Clear flushes the synchronizer too, so a check always starts from a fresh sample.
  always_comb begin
    meta_d  = clear ? 1'b0 : async_in;
    sync_d  = clear ? 1'b0 : meta_q;
    count_d = count_q;
    if (clear || !sync_q) begin
      count_d = 8'd0;
    end else if (count_q != TARGET) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      count_q <= count_d;
    end
  end

  assign synced     = sync_q;
  assign stable_hit = sync_q && (count_q >= (TARGET - 8'd1));

endmodule

// File: rtl/rf_frontend_ctrl.sv
// WSA1000 front-end sequencer: break-before-make switch/filter updates from the settings
// bus, optional VCO load-enable pulse and lock check with timeout, plus a status word.
module rf_frontend_ctrl
  import rf_frontend_ctrl_pkg::*;
#(
  parameter logic [6:0]  ADDR          = FR_FRONTEND,
  parameter logic [15:0] BREAK_CYCLES  = 16'd50,
  parameter logic [15:0] SETTLE_CYCLES = 16'd500,
  parameter logic [7:0]  LE_CYCLES     = 8'd4,
  parameter logic [7:0]  LOCK_STABLE   = 8'd16,
  parameter logic [23:0] LOCK_TIMEOUT  = 24'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        vco_muxout,
  output logic [3:0]  vsw,
  output logic [1:0]  filter_a,
  output logic        vco_le,
  output logic        busy,
  output logic        locked,
  output logic        lock_timeout,
  output logic [31:0] status
);

  localparam logic [23:0] BREAK_LAST  = last_count(24'(BREAK_CYCLES));
  localparam logic [23:0] SETTLE_LAST = last_count(24'(SETTLE_CYCLES));
  localparam logic [23:0] LE_LAST     = last_count(24'(LE_CYCLES));
  localparam logic [23:0] TO_LAST     = last_count(LOCK_TIMEOUT);

  fe_state_e   state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  fe_cmd_t     cur_q, cur_d;
  fe_cmd_t     pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  vsw_q, vsw_d;
  logic [1:0]  filter_q, filter_d;
  logic        vco_le_q, vco_le_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        lock_timeout_q, lock_timeout_d;
  logic [7:0]  lock_checks_q, lock_checks_d;

  logic        wr_hit;
  fe_cmd_t     wr_cmd;
  logic        lock_hit;
  logic        muxout_sync_unused;
  logic        unused_data_bits;

  assign wr_hit           = serial_strobe && (serial_addr == ADDR);
  assign wr_cmd           = decode_cmd(serial_data[8:0]);
  assign unused_data_bits = ^serial_data[31:9];

  sync_debounce #(
    .STABLE(LOCK_STABLE)
  ) u_muxout_sync (
    .clock     (clock),
    .reset     (reset),
    .clear     (state_q != ST_LOCK_WAIT),
    .async_in  (vco_muxout),
    .synced    (muxout_sync_unused),
    .stable_hit(lock_hit)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cur_d          = cur_q;
    pend_d         = pend_q;
    pend_v_d       = pend_v_q;
    vsw_d          = vsw_q;
    filter_d       = filter_q;
    vco_le_d       = vco_le_q;
    busy_d         = busy_q;
    locked_d       = locked_q;
    lock_timeout_d = lock_timeout_q;
    lock_checks_d  = lock_checks_q;

    unique case (state_q)
      ST_IDLE: begin
        // A fresh write is newer than anything pending, so it takes precedence.
        if (wr_hit || pend_v_q) begin
          cur_d    = wr_hit ? wr_cmd : pend_q;
          pend_v_d = 1'b0;
          state_d  = ST_BREAK;
          cnt_d    = 24'd0;
          busy_d   = 1'b1;
          vsw_d    = 4'd0;
        end
      end
      ST_BREAK: begin
        if (cnt_q == BREAK_LAST) begin
          state_d  = ST_MAKE;
          cnt_d    = 24'd0;
          vsw_d    = cur_q.vsw;
          filter_d = cur_q.filter;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_MAKE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = 24'd0;
          if (cur_q.do_vco) begin
            state_d        = ST_LE_PULSE;
            vco_le_d       = 1'b1;
            locked_d       = 1'b0;
            lock_timeout_d = 1'b0;
            lock_checks_d  = lock_checks_q + 8'd1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_LE_PULSE: begin
        if (cnt_q == LE_LAST) begin
          state_d  = ST_LOCK_WAIT;
          cnt_d    = 24'd0;
          vco_le_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_LOCK_WAIT: begin
        // Lock is tested first so it wins a tie with the timeout.
        if (lock_hit) begin
          locked_d = 1'b1;
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          cnt_d    = 24'd0;
        end else if (cnt_q == TO_LAST) begin
          lock_timeout_d = 1'b1;
          state_d        = ST_IDLE;
          busy_d         = 1'b0;
          cnt_d          = 24'd0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = 24'd0;
        busy_d   = 1'b0;
        vco_le_d = 1'b0;
      end
    endcase

    if ((state_q != ST_IDLE) && wr_hit) begin
      pend_v_d = 1'b1;
      pend_d   = wr_cmd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 24'd0;
      cur_q          <= '0;
      pend_q         <= '0;
      pend_v_q       <= 1'b0;
      vsw_q          <= 4'd0;
      filter_q       <= 2'd0;
      vco_le_q       <= 1'b0;
      busy_q         <= 1'b0;
      locked_q       <= 1'b0;
      lock_timeout_q <= 1'b0;
      lock_checks_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cur_q          <= cur_d;
      pend_q         <= pend_d;
      pend_v_q       <= pend_v_d;
      vsw_q          <= vsw_d;
      filter_q       <= filter_d;
      vco_le_q       <= vco_le_d;
      busy_q         <= busy_d;
      locked_q       <= locked_d;
      lock_timeout_q <= lock_timeout_d;
      lock_checks_q  <= lock_checks_d;
    end
  end

  assign vsw          = vsw_q;
  assign filter_a     = filter_q;
  assign vco_le       = vco_le_q;
  assign busy         = busy_q;
  assign locked       = locked_q;
  assign lock_timeout = lock_timeout_q;
  assign status       = {8'd0, lock_checks_q, 1'b0, 3'(state_q), pend_v_q, lock_timeout_q,
                         locked_q, busy_q, 2'b00, filter_q, vsw_q};

endmodule

// File: tb/tb_rf_frontend_ctrl.sv
// Bench for rf_frontend_ctrl: directed scenarios with literal expectations, then random
// writes, muxout patterns and resets, all compared every cycle against a timeline model.
module tb_rf_frontend_ctrl;
  import rf_frontend_ctrl_pkg::*;

  localparam logic [6:0] A_REG = FR_FRONTEND;
  localparam int B_CYC  = 50;
  localparam int S_CYC  = 500;
  localparam int L_CYC  = 4;
  localparam int ST_CYC = 16;
  localparam int T_CYC  = 1500;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  serial_addr = 7'd0;
  logic [31:0] serial_data = 32'd0;
  logic        serial_strobe = 1'b0;
  logic        vco_muxout;
  logic [3:0]  vsw;
  logic [1:0]  filter_a;
  logic        vco_le, busy, locked, lock_timeout;
  logic [31:0] status;

  int vectors = 0;
  int miscompares = 0;
  int mux_mode = 0;
  int tog_cnt = 0;

  rf_frontend_ctrl #(
    .LOCK_TIMEOUT(24'(T_CYC))
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_addr  (serial_addr),
    .serial_data  (serial_data),
    .serial_strobe(serial_strobe),
    .vco_muxout   (vco_muxout),
    .vsw          (vsw),
    .filter_a     (filter_a),
    .vco_le       (vco_le),
    .busy         (busy),
    .locked       (locked),
    .lock_timeout (lock_timeout),
    .status       (status)
  );

  always #10 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // muxout patterns: 0 low, 1 high, 2 toggle every 10 cycles, 3 random mostly-high
  initial begin
    vco_muxout = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      tog_cnt++;
      case (mux_mode)
        0: vco_muxout = 1'b0;
        1: vco_muxout = 1'b1;
        2: if (tog_cnt >= 10) begin vco_muxout = ~vco_muxout; tog_cnt = 0; end
        default: vco_muxout = ($urandom_range(0, 7) != 0);
      endcase
    end
  end

  // Timeline model: a sequence started at edge t0 is in break for B edges, make for S,
  // LE for L, then waits for 16 consecutive synced highs (input delayed by 2 edges after
  // entering the wait) or T cycles.
  int cyc, t0, tw;
  bit act, pend;
  bit [8:0] cur_cmd, pend_cmd;
  bit [3:0] e_vsw;
  bit [1:0] e_flt;
  bit e_le, e_busy, e_lock, e_to;
  bit [7:0] e_chk;
  bit [2:0] e_state;
  bit mh [32];

  function automatic bit window_locked(input int n);
    for (int k = 1; k <= ST_CYC; k++) begin
      if (n - k < tw + 2) return 1'b0;
      if (!mh[(n - k - 1) % 32]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc = 0; act = 0; pend = 0; e_vsw = 0; e_flt = 0; e_le = 0; e_busy = 0;
      e_lock = 0; e_to = 0; e_chk = 0; e_state = 0;
    end else begin
      bit hit;
      int e;
      cyc++;
      mh[cyc % 32] = vco_muxout;
      hit = serial_strobe && (serial_addr == A_REG);
      if (act) begin
        if (hit) begin pend = 1; pend_cmd = serial_data[8:0]; end
        e = cyc - t0;
        if (e_state == 1 && e == B_CYC) begin
          e_state = 2; e_vsw = cur_cmd[3:0]; e_flt = cur_cmd[5:4];
        end else if (e_state == 2 && e == B_CYC + S_CYC) begin
          if (cur_cmd[8]) begin
            e_state = 3; e_le = 1; e_lock = 0; e_to = 0; e_chk++;
          end else begin
            act = 0; e_busy = 0; e_state = 0;
          end
        end else if (e_state == 3 && e == B_CYC + S_CYC + L_CYC) begin
          e_state = 4; e_le = 0; tw = cyc;
        end else if (e_state == 4) begin
          if (window_locked(cyc)) begin
            e_lock = 1; act = 0; e_busy = 0; e_state = 0;
          end else if (cyc - tw == T_CYC) begin
            e_to = 1; act = 0; e_busy = 0; e_state = 0;
          end
        end
      end else if (hit || pend) begin
        cur_cmd = hit ? serial_data[8:0] : pend_cmd;
        pend = 0; act = 1; t0 = cyc; e_state = 1; e_busy = 1; e_vsw = 0;
      end
    end
  end

  always @(negedge clock) begin
    check("outputs", {22'd0, vsw, filter_a, vco_le, busy, locked, lock_timeout},
          {22'd0, e_vsw, e_flt, e_le, e_busy, e_lock, e_to});
    check("status", status, {8'd0, e_chk, 1'b0, e_state, pend, e_to, e_lock, e_busy,
                             2'b00, e_flt, e_vsw});
  end

  task automatic write(input logic [6:0] addr, input logic [31:0] data);
    @(negedge clock);
    #1;
    serial_addr = addr; serial_data = data; serial_strobe = 1'b1;
    $display("write addr=%0d data=%08h mux_mode=%0d t=%0t", addr, data, mux_mode, $time);
    @(negedge clock);
    #1;
    serial_strobe = 1'b0;
  endtask

  // Follows one sequence sample by sample; distances are measured from LOCK_WAIT entry.
  task automatic run_seq(output int n_open, output int n_busy, output int n_le,
                         output int d_lock, output int d_to);
    int tw_i, lk_i, to_i, i;
    bit was_le;
    n_open = 0; n_busy = 0; n_le = 0; tw_i = -1; lk_i = -1; to_i = -1; was_le = 0;
    for (i = 0; i < 6000 && busy; i++) begin
      if (vsw == 4'd0) n_open++;
      n_busy++;
      if (vco_le) n_le++;
      if (was_le && !vco_le && tw_i < 0) tw_i = i;
      if (tw_i >= 0 && locked && lk_i < 0) lk_i = i;
      if (tw_i >= 0 && lock_timeout && to_i < 0) to_i = i;
      was_le = vco_le;
      @(negedge clock);
      #1;
    end
    if (tw_i >= 0 && locked && lk_i < 0) lk_i = i;
    if (tw_i >= 0 && lock_timeout && to_i < 0) to_i = i;
    d_lock = (lk_i >= 0) ? lk_i - tw_i : -1;
    d_to   = (to_i >= 0) ? to_i - tw_i : -1;
  endtask

  initial begin
    int n_open, n_busy, n_le, d_lock, d_to, falls, r, gap;
    bit seen_two, prev_busy;
    logic [6:0] addr;

    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #1;
    check("reset_status", status, 32'd0);
    check("reset_vsw", {28'd0, vsw}, 32'd0);

    // 1: plain switch change, no VCO step
    mux_mode = 0;
    write(A_REG, 32'h0000_002A);
    check("t1_busy_rise", {31'd0, busy}, 32'd1);
    run_seq(n_open, n_busy, n_le, d_lock, d_to);
    check("t1_break_len", n_open, 50);
    check("t1_busy_len", n_busy, 550);
    check("t1_vco_le_cnt", n_le, 0);
    check("t1_vsw", {28'd0, vsw}, 32'hA);
    check("t1_filter", {30'd0, filter_a}, 32'd2);

    // 2: VCO step with muxout high
    mux_mode = 1;
    write(A_REG, 32'h0000_0105);
    run_seq(n_open, n_busy, n_le, d_lock, d_to);
    check("t2_le_width", n_le, 4);
    check("t2_lock_delay", d_lock, 18);
    check("t2_checks", {24'd0, status[23:16]}, 32'd1);
    check("t2_locked", {31'd0, status[9]}, 32'd1);

    // 3: VCO step with muxout low
    mux_mode = 0;
    write(A_REG, 32'h0000_0103);
    run_seq(n_open, n_busy, n_le, d_lock, d_to);
    check("t3_timeout_delay", d_to, T_CYC);
    check("t3_locked", {31'd0, locked}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_status_to", {31'd0, status[10]}, 32'd1);

    // 4: toggling muxout never qualifies
    mux_mode = 2;
    write(A_REG, 32'h0000_0101);
    run_seq(n_open, n_busy, n_le, d_lock, d_to);
    check("t4_no_lock", d_lock, -1);
    check("t4_timeout_delay", d_to, T_CYC);

    // 5: pending overwrite
    mux_mode = 1;
    write(A_REG, 32'h0000_0001);
    repeat (60) @(negedge clock);
    write(A_REG, 32'h0000_0002);
    check("t5_pending", {31'd0, status[11]}, 32'd1);
    write(A_REG, 32'h0000_0004);
    falls = 0; seen_two = 0; prev_busy = busy;
    for (int i = 0; i < 4000 && falls < 2; i++) begin
      @(negedge clock);
      #1;
      if (vsw == 4'd2) seen_two = 1;
      if (prev_busy && !busy) falls++;
      prev_busy = busy;
    end
    check("t5_seq_count", falls, 2);
    check("t5_b_skipped", {31'd0, seen_two}, 32'd0);
    check("t5_final_vsw", {28'd0, vsw}, 32'd4);

    // 6: asynchronous reset during LE pulse
    write(A_REG, 32'h0000_013F);
    for (int i = 0; i < 2000 && !vco_le; i++) begin
      @(negedge clock);
      #1;
    end
    check("t6_reached_le", {31'd0, vco_le}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("t6_async_outs", {24'd0, vsw, filter_a, vco_le, busy}, 32'd0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #1;
    check("t6_status_after", status, 32'd0);
    write(A_REG + 7'd1, 32'h0000_002F);
    repeat (5) @(negedge clock);
    #1;
    check("t6_other_addr", {26'd0, vsw, filter_a}, 32'd0);

    // random phase
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      mux_mode = (r < 6) ? 1 : (r < 8) ? 3 : (r < 9) ? 2 : 0;
      addr = ($urandom_range(0, 7) != 0) ? A_REG : 7'($urandom_range(0, 127));
      write(addr, $urandom);
      gap = $urandom_range(1, 700);
      repeat (gap) @(negedge clock);
      if ($urandom_range(0, 14) == 0) begin
        #4 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
      end
    end
    mux_mode = 1;
    for (int i = 0; i < 8000 && (busy || status[11]); i++) begin
      @(negedge clock);
      #1;
    end
    check("drain_idle", {31'd0, busy}, 32'd0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
